// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES pad poll scheduler: button bit indices, the
// poll sequencer state type, the 8-bit button vector type and a small helper
// used to size counters from parameters.
// -----------------------------------------------------------------------------
package nes_pkg;

   // Button bit positions; also the serial slot index in which each bit arrives.
   localparam int unsigned BTN_A    = 0;
   localparam int unsigned BTN_B    = 1;
   localparam int unsigned BTN_SEL  = 2;
   localparam int unsigned BTN_STRT = 3;
   localparam int unsigned BTN_UP   = 4;
   localparam int unsigned BTN_DN   = 5;
   localparam int unsigned BTN_L    = 6;
   localparam int unsigned BTN_R    = 7;

   localparam int unsigned NUM_BTN  = 8;

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      SHIFT,
      DONE
   } poll_state_t;

   typedef logic [NUM_BTN-1:0] btn_vec_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for a single asynchronous input bit.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (both flops clear to 0)
//   i_d      asynchronous input
//   o_q      input resynchronized to i_clk, two cycles of latency
// -----------------------------------------------------------------------------
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/nes_poll_scheduler.sv
// -----------------------------------------------------------------------------
// nes_poll_scheduler
// Single owner of the shared NES latch / serial clock lines for two pad ports.
// Polls on a fixed period (while enabled) or on request, shifts both pads in
// simultaneously and publishes per-frame button vectors plus newly-pressed
// edges with a one-cycle valid strobe.
//
// Parameters:
//   HALF_PER     system clocks per nes_clk half-period (>= 4)
//   LATCH_CYC    system clocks nes_latch is held high (>= 2)
//   POLL_PERIOD  system clocks between automatic polls
//                (> LATCH_CYC + 16*HALF_PER + 2)
//
// Ports:
//   i_clk              system clock
//   i_rst_n            asynchronous active-low reset
//   i_en               enables automatic and requested polls
//   i_poll_req         single-cycle on-demand poll request
//   o_poll_busy        high from poll acceptance through the valid cycle
//   o_nes_latch        shared latch to both pads (registered)
//   o_nes_clk          shared serial clock to both pads (registered)
//   i_nes_d1/i_nes_d2  serial pad data, active-low, asynchronous
//   o_btn1/o_btn2      current button state, active-high
//   o_press1/o_press2  buttons newly pressed in the latest poll
//   o_valid            one-cycle strobe; btn/press updated this cycle
// -----------------------------------------------------------------------------
module nes_poll_scheduler
   import nes_pkg::*;
#(
   parameter int unsigned HALF_PER    = 300,
   parameter int unsigned LATCH_CYC   = 600,
   parameter int unsigned POLL_PERIOD = 833_333
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_poll_req,
   output logic       o_poll_busy,
   output logic       o_nes_latch,
   output logic       o_nes_clk,
   input  logic       i_nes_d1,
   input  logic       i_nes_d2,
   output logic [7:0] o_btn1,
   output logic [7:0] o_btn2,
   output logic [7:0] o_press1,
   output logic [7:0] o_press2,
   output logic       o_valid
);

   // One phase counter serves both the latch pulse and each shift slot.
   localparam int unsigned PHASE_W = $clog2(max_u(LATCH_CYC, 2 * HALF_PER));
   localparam int unsigned PER_W   = $clog2(POLL_PERIOD);

   localparam logic [PHASE_W-1:0] PH_LATCH_LAST = PHASE_W'(LATCH_CYC - 1);
   localparam logic [PHASE_W-1:0] PH_LOW_LAST   = PHASE_W'(HALF_PER - 1);
   localparam logic [PHASE_W-1:0] PH_SLOT_LAST  = PHASE_W'(2 * HALF_PER - 1);
   localparam logic [PER_W-1:0]   PER_LAST      = PER_W'(POLL_PERIOD - 1);
   localparam logic [2:0]         SLOT_FIRST    = 3'(BTN_A);
   localparam logic [2:0]         SLOT_LAST     = 3'(BTN_R);

   // ---------------------------------------------------------------------------
   // Synchronized pad data
   // ---------------------------------------------------------------------------
   logic w_d1_sync;
   logic w_d2_sync;

   sync2 u_sync_d1 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_nes_d1),
      .o_q     (w_d1_sync)
   );

   sync2 u_sync_d2 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_nes_d2),
      .o_q     (w_d2_sync)
   );

   // ---------------------------------------------------------------------------
   // Trigger generation: period counter and single pending flag
   // ---------------------------------------------------------------------------
   poll_state_t      r_state;
   logic [PER_W-1:0] r_per_cnt;
   logic             r_pending;
   logic             w_wrap;
   logic             w_trigger;
   logic             w_accept;

   assign w_wrap    = i_en && (r_per_cnt == PER_LAST);
   assign w_trigger = i_en && (i_poll_req || w_wrap);
   assign w_accept  = (r_state == IDLE) && r_pending;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_per_cnt <= '0;
      end else if (!i_en || w_wrap) begin
         r_per_cnt <= '0;
      end else begin
         r_per_cnt <= r_per_cnt + 1'b1;
      end
   end

   // Set wins over clear so a trigger on the acceptance cycle queues a new poll.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending <= 1'b0;
      end else if (w_trigger) begin
         r_pending <= 1'b1;
      end else if (w_accept) begin
         r_pending <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Poll sequencer with registered outputs
   // ---------------------------------------------------------------------------
   logic [PHASE_W-1:0] r_phase;
   logic [2:0]         r_slot;
   btn_vec_t           r_raw1;
   btn_vec_t           r_raw2;
   logic               r_latch;
   logic               r_nes_clk;
   logic               r_busy;
   logic               r_valid;
   btn_vec_t           r_btn1;
   btn_vec_t           r_btn2;
   btn_vec_t           r_press1;
   btn_vec_t           r_press2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_phase   <= '0;
         r_slot    <= '0;
         r_raw1    <= '0;
         r_raw2    <= '0;
         r_latch   <= 1'b0;
         r_nes_clk <= 1'b0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_btn1    <= '0;
         r_btn2    <= '0;
         r_press1  <= '0;
         r_press2  <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= LATCH;
                  r_latch <= 1'b1;
                  r_busy  <= 1'b1;
                  r_phase <= '0;
               end
            end

            LATCH: begin
               if (r_phase == PH_LATCH_LAST) begin
                  r_state <= SHIFT;
                  r_latch <= 1'b0;
                  r_phase <= '0;
                  r_slot  <= SLOT_FIRST;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end

            SHIFT: begin
               // Last low-half cycle: sample, and raise nes_clk for the high half.
               if (r_phase == PH_LOW_LAST) begin
                  r_raw1[r_slot] <= w_d1_sync;
                  r_raw2[r_slot] <= w_d2_sync;
                  r_nes_clk      <= 1'b1;
               end
               if (r_phase == PH_SLOT_LAST) begin
                  r_phase   <= '0;
                  r_nes_clk <= 1'b0;
                  if (r_slot == SLOT_LAST) begin
                     // Raw data is active-low; the old btn is the previous frame.
                     r_state  <= DONE;
                     r_valid  <= 1'b1;
                     r_btn1   <= ~r_raw1;
                     r_btn2   <= ~r_raw2;
                     r_press1 <= ~r_raw1 & ~r_btn1;
                     r_press2 <= ~r_raw2 & ~r_btn2;
                  end else begin
                     r_slot <= r_slot + 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end

            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_poll_busy = r_busy;
   assign o_nes_latch = r_latch;
   assign o_nes_clk   = r_nes_clk;
   assign o_valid     = r_valid;
   assign o_btn1      = r_btn1;
   assign o_btn2      = r_btn2;
   assign o_press1    = r_press1;
   assign o_press2    = r_press2;

endmodule
